// File: rtl/multicycle_control_v2.sv
// Multicycle MIPS control unit: main FSM plus ALU decoder. Memory states can
// stall on mem_ready, and the extended ops (bne/andi/ori/j) can be disabled.
module multicycle_control_v2 #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_OPS       = 1'b1,
  parameter int ALU_CTRL_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  i_or_d,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  branch,
  output logic                  branch_ne,
  output logic                  reg_write,
  output logic                  reg_dest,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  imm_zext,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  BNEEX   = 4'd9,  ADDIEX  = 4'd10, LOGIEX  = 4'd11,
    IWB     = 4'd12, JEX     = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state;
  state_t     dec_next;
  logic       dec_illegal;
  logic       rtype_ok;
  logic [2:0] rtype_alu;
  logic [2:0] rtype_alu_q;
  logic       sw_q;
  logic       logi_or_q;
  logic       mem_rdy;
  logic [2:0] alu_code;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin : funct_decode
    rtype_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_ok  = 1'b0;
    endcase
  end

  always_comb begin : opcode_decode
    dec_next    = FETCH;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LW, OP_SW: dec_next = MEMADR;
      OP_R:         if (rtype_ok) dec_next = RTYPEEX; else dec_illegal = 1'b1;
      OP_BEQ:       dec_next = BEQEX;
      OP_ADDI:      dec_next = ADDIEX;
      OP_BNE:       if (EXT_OPS) dec_next = BNEEX; else dec_illegal = 1'b1;
      OP_ANDI,
      OP_ORI:       if (EXT_OPS) dec_next = LOGIEX; else dec_illegal = 1'b1;
      OP_J:         if (EXT_OPS) dec_next = JEX; else dec_illegal = 1'b1;
      default:      dec_illegal = 1'b1;
    endcase
  end

  // Instruction fields are captured in DECODE so later states never look at the IR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      sw_q        <= 1'b0;
      logi_or_q   <= 1'b0;
      rtype_alu_q <= ALU_ADD;
    end else begin
      case (state)
        FETCH:   if (mem_rdy) state <= DECODE;
        DECODE: begin
          state       <= dec_next;
          sw_q        <= (opcode == OP_SW);
          logi_or_q   <= (opcode == OP_ORI);
          rtype_alu_q <= rtype_alu;
        end
        MEMADR:  state <= sw_q ? MEMWR : MEMRD;
        MEMRD:   if (mem_rdy) state <= MEMWB;
        MEMWR:   if (mem_rdy) state <= FETCH;
        RTYPEEX: state <= RTYPEWB;
        ADDIEX,
        LOGIEX:  state <= IWB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin : output_decode
    mem_req    = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    reg_write  = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    alu_code   = ALU_ADD;
    illegal    = 1'b0;
    state_dbg  = state;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        illegal   = dec_illegal;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_code  = rtype_alu_q;
      end
      RTYPEWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      BEQEX, BNEEX: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = 2'b01;
        branch    = (state == BEQEX);
        branch_ne = (state == BNEEX);
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      LOGIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_zext  = 1'b1;
        alu_code  = logi_or_q ? ALU_OR : ALU_AND;
      end
      IWB:     reg_write = 1'b1;
      JEX: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
    // Reset overrides everything so no write strobe escapes in the reset cycle.
    if (reset) begin
      mem_req    = 1'b0;
      i_or_d     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      reg_write  = 1'b0;
      reg_dest   = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      pc_src     = 2'b00;
      alu_code   = 3'b000;
      illegal    = 1'b0;
      state_dbg  = 4'd0;
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_code);

endmodule
